// File: rtl/lstm_pkg.sv
// Shared LSTM datapath parameters and the weight-loader state encoding.
package lstm_pkg;

  localparam int D_WL_DEF      = 24;
  localparam int UNITS_NUM_DEF = 5;
  localparam int DEPTH_DEF     = 180;
  localparam int AW_DEF        = 8;

  typedef logic [1:0] wbuf_state_t;

  localparam wbuf_state_t ST_IDLE = 2'd0;
  localparam wbuf_state_t ST_LOAD = 2'd1;
  localparam wbuf_state_t ST_DONE = 2'd2;

  // Counter width that stays legal when the count range collapses to one value.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wbuf_ram.sv
// Simple dual-port weight storage: one synchronous write port, one synchronous read port.
module wbuf_ram #(
  parameter int W     = 120,
  parameter int DEPTH = 180,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [0:DEPTH-1];
  logic [W-1:0] r_q;

  // Row write; the array carries no reset, stale rows are masked by the loader.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Row read, gated so only committed (in-range) rows are ever addressed.
  always_ff @(posedge clk) begin
    if (i_re) begin
      r_q <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/wbuf_loader.sv
// Run-time loadable LSTM weight buffer: packs streamed words MSB-first into rows,
// stores DEPTH rows and serves a 1-cycle registered row read masked by rows_loaded.
module wbuf_loader
  import lstm_pkg::*;
#(
  parameter int D_WL      = D_WL_DEF,
  parameter int UNITS_NUM = UNITS_NUM_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int AW        = AW_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load_start,
  input  logic                      wr_valid,
  input  logic [D_WL-1:0]           wr_data,
  output logic                      wr_ready,
  output logic                      load_busy,
  output logic                      load_done,
  output logic [AW-1:0]             rows_loaded,
  input  logic [AW-1:0]             addr,
  output logic [UNITS_NUM*D_WL-1:0] w_o
);

  localparam int RW    = UNITS_NUM * D_WL;
  localparam int ASM_W = RW - D_WL;
  localparam int WCW   = cnt_width(UNITS_NUM);

  localparam logic [WCW-1:0] LAST_WORD = WCW'(UNITS_NUM - 1);
  localparam logic [AW-1:0]  LAST_ROW  = AW'(DEPTH - 1);

  wbuf_state_t      r_state;
  logic [WCW-1:0]   r_word_cnt;
  logic [AW-1:0]    r_row_cnt;
  logic [AW-1:0]    r_rows_loaded;
  logic [ASM_W-1:0] r_asm;
  logic             r_rd_ok;

  logic             w_wr_ready;
  logic             w_accept;
  logic             w_commit;
  logic             w_rd_en;
  logic [RW-1:0]    w_ram_q;

  // Restart has priority over data, so ready drops in the load_start cycle.
  assign w_wr_ready = (r_state == ST_LOAD) && !load_start;
  assign w_accept   = w_wr_ready && wr_valid;
  assign w_commit   = w_accept && (r_word_cnt == LAST_WORD);
  assign w_rd_en    = (addr < r_rows_loaded);

  // Load sequencing: restart clears the counters, commits advance the row pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_word_cnt    <= '0;
      r_row_cnt     <= '0;
      r_rows_loaded <= '0;
    end else if (load_start) begin
      r_state       <= ST_LOAD;
      r_word_cnt    <= '0;
      r_row_cnt     <= '0;
      r_rows_loaded <= '0;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= ST_IDLE;
        ST_DONE: r_state <= ST_DONE;
        ST_LOAD: begin
          if (w_commit) begin
            r_word_cnt    <= '0;
            r_rows_loaded <= r_rows_loaded + AW'(1);
            if (r_row_cnt == LAST_ROW) begin
              r_state <= ST_DONE;
            end else begin
              r_row_cnt <= r_row_cnt + AW'(1);
            end
          end else if (w_accept) begin
            r_word_cnt <= r_word_cnt + WCW'(1);
          end else begin
            r_word_cnt <= r_word_cnt;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Row assembly: earlier words migrate toward the MSB end as new ones arrive.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_asm <= (r_asm << D_WL) | ASM_W'(wr_data);
    end
  end

  // Read mask uses the pre-edge row count, so a row committing now still reads 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ok <= 1'b0;
    end else begin
      r_rd_ok <= w_rd_en;
    end
  end

  wbuf_ram #(
    .W     (RW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_commit),
    .i_waddr (r_row_cnt),
    .i_wdata ({r_asm, wr_data}),
    .i_re    (w_rd_en),
    .i_raddr (addr),
    .o_rdata (w_ram_q)
  );

  assign w_o         = r_rd_ok ? w_ram_q : {RW{1'b0}};
  assign wr_ready    = w_wr_ready;
  assign load_busy   = (r_state == ST_LOAD);
  assign load_done   = (r_state == ST_DONE);
  assign rows_loaded = r_rows_loaded;

endmodule

// File: tb/tb_wbuf_loader.sv
// Self-checking bench for wbuf_loader: randomised word streams against a
// word-list model where row r is simply words r*UN .. r*UN+UN-1, MSB first.
module tb_wbuf_loader;

  localparam int DW  = 24;
  localparam int UN  = 5;
  localparam int DEP = 180;
  localparam int AWW = 8;
  localparam int RW  = UN * DW;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           load_start;
  logic           wr_valid;
  logic [DW-1:0]  wr_data;
  logic           wr_ready;
  logic           load_busy;
  logic           load_done;
  logic [AWW-1:0] rows_loaded;
  logic [AWW-1:0] addr;
  logic [RW-1:0]  w_o;

  always #5 clk = ~clk;

  wbuf_loader #(.D_WL(DW), .UNITS_NUM(UN), .DEPTH(DEP), .AW(AWW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_start  (load_start),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .load_busy   (load_busy),
    .load_done   (load_done),
    .rows_loaded (rows_loaded),
    .addr        (addr),
    .w_o         (w_o)
  );

  logic [DW-1:0] acc [0:DEP*UN-1];
  int n_acc;
  int n_checks;
  int n_pass;

  // Reference row: committed rows are whole groups of UN accepted words.
  function automatic logic [RW-1:0] exp_row(input int a);
    logic [RW-1:0] r;
    r = '0;
    if (a < n_acc / UN) begin
      for (int k = 0; k < UN; k++) r = (r << DW) | RW'(acc[a*UN+k]);
    end
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input int a, output logic [RW-1:0] q);
    addr = AWW'(a);
    tick();
    q = w_o;
  endtask

  task automatic start_load;
    load_start = 1'b1;
    wr_valid   = 1'b1;
    wr_data    = 24'($urandom());
    #1;
    n_checks++;
    if (wr_ready !== 1'b0) $display("FAIL start_ready_low: got %b want 0", wr_ready);
    else n_pass++;
    tick();
    load_start = 1'b0;
    wr_valid   = 1'b0;
    n_acc      = 0;
    #1;
    n_checks++;
    if ({wr_ready, load_busy, load_done} !== 3'b110 || rows_loaded !== 8'd0)
      $display("FAIL start_state: got rdy/busy/done=%b rows=%0d want 110 rows=0",
               {wr_ready, load_busy, load_done}, rows_loaded);
    else n_pass++;
  endtask

  task automatic send_words(input int n, input int gap_pct, input bit rnd);
    int  sent;
    int  guard;
    bit  acc_now;
    sent  = 0;
    guard = 0;
    while (sent < n && guard < n * 10 + 50) begin
      wr_valid = ($urandom_range(99) >= gap_pct);
      wr_data  = rnd ? 24'($urandom()) : 24'(n_acc);
      #1;
      acc_now = wr_valid && wr_ready;
      tick();
      if (acc_now && n_acc < DEP * UN) begin
        acc[n_acc] = wr_data;
        n_acc++;
        sent++;
      end
      guard++;
    end
    wr_valid = 1'b0;
    n_checks++;
    if (sent != n) $display("FAIL send_timeout: got %0d accepted want %0d", sent, n);
    else n_pass++;
  endtask

  task automatic test_reset;
    logic [RW-1:0] q;
    rst_n      = 1'b0;
    load_start = 1'b0;
    wr_valid   = 1'b1;
    wr_data    = 24'($urandom());
    addr       = AWW'($urandom_range(255));
    repeat (3) tick();
    n_checks++;
    if ({wr_ready, load_busy, load_done} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000", {wr_ready, load_busy, load_done});
    else n_pass++;
    n_checks++;
    if (rows_loaded !== 8'd0) $display("FAIL reset_rows: got %0d want 0", rows_loaded);
    else n_pass++;
    n_checks++;
    if (w_o !== '0) $display("FAIL reset_wo: got %h want 0", w_o);
    else n_pass++;
    rst_n = 1'b1;
    n_acc = 0;
    do_read($urandom_range(DEP - 1), q);
    n_checks++;
    if (q !== '0 || wr_ready !== 1'b0)
      $display("FAIL idle_read: got w_o=%h rdy=%b want 0/0", q, wr_ready);
    else n_pass++;
    wr_valid = 1'b0;
  endtask

  task automatic test_full_load(input int gap_pct);
    logic [RW-1:0] q;
    int            r;
    logic [RW-1:0] row0_lit;
    start_load();
    send_words(DEP * UN - 1, gap_pct, 1'b0);
    n_checks++;
    if (load_done !== 1'b0 || load_busy !== 1'b1 || rows_loaded !== 8'd179)
      $display("FAIL pre_done: got done=%b busy=%b rows=%0d want 0/1/179",
               load_done, load_busy, rows_loaded);
    else n_pass++;
    send_words(1, gap_pct, 1'b0);
    n_checks++;
    if (load_done !== 1'b1 || load_busy !== 1'b0 || rows_loaded !== 8'd180)
      $display("FAIL done: got done=%b busy=%b rows=%0d want 1/0/180",
               load_done, load_busy, rows_loaded);
    else n_pass++;
    wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (wr_ready !== 1'b0) $display("FAIL done_ready: got %b want 0", wr_ready);
      else n_pass++;
      tick();
    end
    wr_valid = 1'b0;
    row0_lit = {24'd0, 24'd1, 24'd2, 24'd3, 24'd4};
    do_read(0, q);
    n_checks++;
    if (q !== row0_lit) $display("FAIL row0: got %h want %h", q, row0_lit);
    else n_pass++;
    do_read(179, q);
    n_checks++;
    if (q !== {24'd895, 24'd896, 24'd897, 24'd898, 24'd899})
      $display("FAIL row179: got %h want words 895..899", q);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      r = $urandom_range(DEP - 1);
      do_read(r, q);
      n_checks++;
      if (q !== exp_row(r)) $display("FAIL row_rand[%0d]: got %h want %h", r, q, exp_row(r));
      else n_pass++;
    end
    do_read(200, q);
    n_checks++;
    if (q !== '0) $display("FAIL addr200: got %h want 0", q);
    else n_pass++;
  endtask

  task automatic test_abort;
    logic [RW-1:0] q;
    start_load();
    send_words(12, 30, 1'b1);
    n_checks++;
    if (rows_loaded !== 8'd2) $display("FAIL abort_pre_rows: got %0d want 2", rows_loaded);
    else n_pass++;
    load_start = 1'b1;
    wr_valid   = 1'b1;
    wr_data    = 24'($urandom());
    #1;
    n_checks++;
    if (wr_ready !== 1'b0) $display("FAIL abort_ready: got %b want 0", wr_ready);
    else n_pass++;
    tick();
    load_start = 1'b0;
    wr_valid   = 1'b0;
    n_acc      = 0;
    n_checks++;
    if (rows_loaded !== 8'd0 || load_busy !== 1'b1)
      $display("FAIL abort_rows: got rows=%0d busy=%b want 0/1", rows_loaded, load_busy);
    else n_pass++;
    send_words(10, 20, 1'b1);
    for (int r = 0; r < 3; r++) begin
      do_read(r, q);
      n_checks++;
      if (q !== exp_row(r)) $display("FAIL abort_row[%0d]: got %h want %h", r, q, exp_row(r));
      else n_pass++;
    end
  endtask

  task automatic test_masking;
    logic [RW-1:0] q;
    start_load();
    send_words(35, 25, 1'b1);
    do_read(6, q);
    n_checks++;
    if (q !== exp_row(6)) $display("FAIL mask_row6: got %h want %h", q, exp_row(6));
    else n_pass++;
    do_read(7, q);
    n_checks++;
    if (q !== '0) $display("FAIL mask_row7: got %h want 0", q);
    else n_pass++;
  endtask

  task automatic test_same_cycle;
    bit acc_now;
    start_load();
    send_words(19, 20, 1'b1);
    addr     = 8'd3;
    wr_valid = 1'b1;
    wr_data  = 24'($urandom());
    #1;
    acc_now = wr_ready;
    tick();
    if (acc_now) begin
      acc[n_acc] = wr_data;
      n_acc++;
    end
    wr_valid = 1'b0;
    n_checks++;
    if (rows_loaded !== 8'd4 || w_o !== '0)
      $display("FAIL commit_edge: got rows=%0d w_o=%h want 4/0", rows_loaded, w_o);
    else n_pass++;
    tick();
    n_checks++;
    if (w_o !== exp_row(3)) $display("FAIL commit_next: got %h want %h", w_o, exp_row(3));
    else n_pass++;
  endtask

  task automatic test_reset_midload;
    logic [RW-1:0] q;
    start_load();
    send_words(8, 0, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_acc = 0;
    n_checks++;
    if ({wr_ready, load_busy, load_done} !== 3'b000 || rows_loaded !== 8'd0)
      $display("FAIL midload_reset: got flags=%b rows=%0d want 000/0",
               {wr_ready, load_busy, load_done}, rows_loaded);
    else n_pass++;
    do_read(0, q);
    n_checks++;
    if (q !== '0) $display("FAIL midload_read: got %h want 0", q);
    else n_pass++;
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    n_acc      = 0;
    rst_n      = 1'b0;
    load_start = 1'b0;
    wr_valid   = 1'b0;
    wr_data    = '0;
    addr       = '0;
    test_reset();
    test_full_load(0);
    test_full_load(35);
    test_abort();
    test_masking();
    test_same_cycle();
    test_reset_midload();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wbuf_loader.md
# wbuf_loader

Writable weight buffer for the LSTM datapath: the write-side counterpart to the fixed-weight read-only buffer. A host or DMA streams `D_WL`-bit signed fixed-point weights one word per handshake; the block packs each group of `UNITS_NUM` words into one row, writes `DEPTH` rows, then serves the same `addr -> w_o` row read used by the LSTM units. Weights can therefore be reloaded at run time instead of being synthesised in.

## Interface
- `D_WL`, 24: weight word width in bits.
- `UNITS_NUM`, 5: words per row (one per LSTM unit).
- `DEPTH`, 180: number of rows.
- `AW`, 8: address width; must satisfy `2^AW >= DEPTH`.

Ports:
- `clk`  in  1  clock. One clock domain; all logic on the rising edge.
- `rst_n`  in  1  reset: synchronous, active-low.
- `load_start`  in  1  one-cycle pulse that begins or restarts a load.
- `wr_valid`  in  1  `wr_data` is valid.
- `wr_data`  in  `D_WL`  weight word.
- `wr_ready`  out  1  word accepted when `wr_valid && wr_ready`.
- `load_busy`  out  1  high while a load is in progress.
- `load_done`  out  1  high from completion of a load until the next `load_start`.
- `rows_loaded`  out  `AW`  number of rows committed so far.
- `addr`  in  `AW`  read row address.
- `w_o`  out  `UNITS_NUM*D_WL`  registered read data.

## Operation
- FSM with three states.
  - IDLE: `wr_ready=0`. `load_start` moves to LOAD and clears `word_cnt`, `row_cnt` and `rows_loaded`.
  - LOAD: `wr_ready = !load_start`. Each accepted word shifts into the row assembly register.
  - DONE: `load_done=1`, `wr_ready=0`. `load_start` moves to LOAD and clears everything as in IDLE.
- Packing order is MSB-first. Word 0 of a row lands in bits `[UNITS_NUM*D_WL-1 -: D_WL]`; word `UNITS_NUM-1` lands in `[D_WL-1:0]`.
- Row commit: on the accept of word `UNITS_NUM-1`, the block writes `{assembly, wr_data}` to `mem[row_cnt]` at that edge, then increments `rows_loaded` and `row_cnt` and resets `word_cnt` to 0.
- Load completion: the commit of row `DEPTH-1` moves the FSM to DONE, with `load_done=1` and `load_busy=0` from the next cycle.
- `load_start` while in LOAD aborts the load and restarts it.
  - Priority is restart over data: `wr_ready` is low in that cycle, so no word is accepted.
  - The partial row is discarded and `rows_loaded` goes to 0.
- Read port:
  - `w_o <= (addr < rows_loaded) ? mem[addr] : 0`.
  - Addresses at or above `DEPTH`, and rows not yet committed, read as 0.
  - Reads are legal in every state.
- `load_busy = (state==LOAD)`.
- Words are raw two's-complement values. The block performs no arithmetic on data; the counters are the only arithmetic, and none of them wraps: `row_cnt` stops at `DEPTH-1` and the FSM leaves LOAD.

## Timing
- Reset values: state IDLE, `wr_ready=0`, `load_busy=0`, `load_done=0`, `rows_loaded=0`, `w_o=0`, all counters 0. Memory contents are not reset; they are masked by `rows_loaded`.
- Read latency is 1 cycle (address in cycle N, `w_o` valid in cycle N+1).
- Read of the row being committed in the same cycle returns 0, because the read sees the pre-edge `rows_loaded`. The data is visible from the following read.
- `load_start` in cycle N gives `wr_ready=1` in cycle N+1.
- Maximum throughput is one word per cycle, so a full load takes `DEPTH*UNITS_NUM` accepted words; `wr_valid` may gap arbitrarily.
- Reset asserted mid-load returns the block to reset values at the next edge, discarding the partial load.

## Structure
- Shared package `lstm_pkg`: default `D_WL`, `UNITS_NUM`, `DEPTH`, `AW`, and the FSM state encoding (IDLE, LOAD, DONE).
- One sub-module, `wbuf_ram`: simple dual-port RAM with `DEPTH x UNITS_NUM*D_WL` storage, one synchronous write port and one synchronous read port, with no reset on the array. The masking and the FSM stay in `wbuf_loader`.

## Test plan
- Reset: hold `rst_n=0` for 3 cycles while driving `wr_valid=1` -> all outputs 0; any `addr` reads 0.
- Full load: `load_start`, then words with value equal to the global index 0..899 sent back-to-back.
  - Expected: `load_done` high after the 900th accept; `rows_loaded=180`.
  - `addr=0` returns `{24'd0, 24'd1, 24'd2, 24'd3, 24'd4}`; `addr=179` returns words 895..899.
- Backpressure and gaps: randomised `wr_valid` gaps during the full load -> identical memory image; `wr_ready` never high in IDLE or DONE.
- Abort: `load_start` after 12 accepted words -> `wr_ready=0` that cycle and `rows_loaded=0`. A subsequent load with new data makes row 0 hold only the new data.
- Masking: after 7 committed rows, `addr=6` returns data and `addr=7` returns 0. Also `addr=200` after a full load returns 0.
- Same-cycle read/commit: `addr=3` held while row 3 commits -> 0 in the cycle after the commit edge, row data one cycle later.
